// File: rtl/dumbserial_pkg.sv
// rtl/dumbserial_pkg.sv - shared constants and types for the dumb-serial link
//
// Holds the start-frame delimiter, the transmitter bit timing and the
// receive state enum used by the frame receiver.
package dumbserial_pkg;

    localparam logic [7:0] SFD              = 8'hAB;
    localparam int         SFD_BITS         = 8;

    // Transmitter holds serialClock high/low this many cycles per bit; the
    // receiver treats a run of HIGH_CYCLES_READ highs as a bit strobe.
    localparam int         HIGH_CYCLES      = 8;
    localparam int         LOW_CYCLES       = 8;
    localparam int         HIGH_CYCLES_READ = 6;

    typedef enum logic {
        SEEK = 1'b0,
        RECV = 1'b1
    } rx_state_t;

endpackage

// File: rtl/dumbserial_bit_sampler.sv
// rtl/dumbserial_bit_sampler.sv - recovers bits from the serialClock/serialData pair
//
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   serialClock            link clock (already synchronised)
//   serialData             link data
//   bit_valid              one-cycle strobe: bit_data holds a new bit
//   bit_data               recovered bit
module dumbserial_bit_sampler
    import dumbserial_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic serialClock,
    input  logic serialData,
    output logic bit_valid,
    output logic bit_data
);

    logic [HIGH_CYCLES_READ-1:0] hist;
    logic [HIGH_CYCLES_READ-1:0] hist_next;

    assign hist_next = {hist[HIGH_CYCLES_READ-2:0], serialClock};

    // Clearing the history on a hit means the remaining high cycles of the
    // same bit cannot produce a second strobe before the low phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist      <= '0;
            bit_valid <= 1'b0;
            bit_data  <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            if (&hist_next) begin
                hist      <= '0;
                bit_valid <= 1'b1;
                bit_data  <= serialData;
            end else begin
                hist <= hist_next;
            end
        end
    end

endmodule

// File: rtl/dumbserial_frame_rx_fifo.sv
// rtl/dumbserial_frame_rx_fifo.sv - frame receiver with packet-committed output FIFO
//
// Hunts for the SFD, deserialises 2^LOGSIZE samples per packet into a FIFO
// and only exposes a packet once all of its samples are stored. A packet
// that does not fit (or is aborted) is rewound and dropped as a whole.
//
// Optional feature macro: RX_TIMEOUT_EN (idle-bit abort while receiving).
//
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   serialClock/Data       link inputs
//   out_data/out_last      head sample and its end-of-packet flag
//   out_valid/out_ready    output stream handshake
//   packet_dropped         one-cycle pulse per discarded packet
//   level                  committed entries held
module dumbserial_frame_rx_fifo
    import dumbserial_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int LOGSIZE        = 1,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     serialClock,
    input  logic                     serialData,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     packet_dropped,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int NPKT = 1 << LOGSIZE;
    localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IW   = (LOGSIZE > 0) ? LOGSIZE : 1;

    logic bit_valid;
    logic bit_data;

    dumbserial_bit_sampler u_sampler (
        .clock       (clock),
        .reset       (reset),
        .serialClock (serialClock),
        .serialData  (serialData),
        .bit_valid   (bit_valid),
        .bit_data    (bit_data)
    );

    rx_state_t             state;
    logic [SFD_BITS-2:0]   sfd_shift;
    logic [SFD_BITS-1:0]   sfd_next;
    logic [BW-1:0]         bit_cnt;
    logic [IW-1:0]         idx;
    logic [WIDTH-2:0]      sample;
    logic [WIDTH-1:0]      sample_next;
    logic [PW-1:0]         wr_spec;
    logic [PW-1:0]         wr_commit;
    logic [PW-1:0]         rd;
    logic [PW-1:0]         used;
    logic                  full;
    logic                  last_sample;
    logic                  wr_en;
    logic                  pop;
    logic [WIDTH:0]        mem [DEPTH];

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
`endif

    assign sfd_next    = {sfd_shift, bit_data};
    assign sample_next = {sample, bit_data};
    // Occupancy counts speculative entries too; a same-cycle pop is not credited.
    assign used        = wr_spec - rd;
    assign full        = (used == PW'(DEPTH));
    assign last_sample = (idx == IW'(NPKT - 1));
    assign wr_en       = !reset && (state == RECV) && bit_valid && (bit_cnt == '0) && !full;

    assign out_valid   = (rd != wr_commit);
    assign pop         = out_valid && out_ready;
    assign out_data    = out_valid ? mem[rd[AW-1:0]][WIDTH-1:0] : '0;
    assign out_last    = out_valid ? mem[rd[AW-1:0]][WIDTH]     : 1'b0;
    assign level       = wr_commit - rd;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_spec[AW-1:0]] <= {last_sample, sample_next};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= SEEK;
            sfd_shift      <= '0;
            bit_cnt        <= '0;
            idx            <= '0;
            sample         <= '0;
            wr_spec        <= '0;
            wr_commit      <= '0;
            rd             <= '0;
            packet_dropped <= 1'b0;
`ifdef RX_TIMEOUT_EN
            idle_cnt       <= '0;
`endif
        end else begin
            packet_dropped <= 1'b0;
            if (pop) begin
                rd <= rd + 1'b1;
            end
            case (state)
                SEEK: begin
                    if (bit_valid) begin
                        sfd_shift <= sfd_next[SFD_BITS-2:0];
                        if (sfd_next == SFD) begin
                            state   <= RECV;
                            bit_cnt <= BW'(WIDTH - 1);
                            idx     <= '0;
                            wr_spec <= wr_commit;
`ifdef RX_TIMEOUT_EN
                            idle_cnt <= '0;
`endif
                        end
                    end
                end
                RECV: begin
                    if (bit_valid) begin
                        sample <= sample_next[WIDTH-2:0];
                        if (bit_cnt != '0) begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end else if (full) begin
                            // No room: rewind everything written for this packet.
                            wr_spec        <= wr_commit;
                            packet_dropped <= 1'b1;
                            state          <= SEEK;
                            sfd_shift      <= '0;
                        end else begin
                            wr_spec <= wr_spec + 1'b1;
                            if (last_sample) begin
                                wr_commit <= wr_spec + 1'b1;
                                state     <= SEEK;
                                sfd_shift <= '0;
                            end else begin
                                idx     <= idx + 1'b1;
                                bit_cnt <= BW'(WIDTH - 1);
                            end
                        end
                    end
`ifdef RX_TIMEOUT_EN
                    if (bit_valid) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == TW'(TIMEOUT_CYCLES)) begin
                        wr_spec        <= wr_commit;
                        packet_dropped <= 1'b1;
                        state          <= SEEK;
                        sfd_shift      <= '0;
                        idle_cnt       <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end
                default: state <= SEEK;
            endcase
        end
    end

endmodule

// File: tb/tb_dumbserial_frame_rx_fifo.sv
// tb/tb_dumbserial_frame_rx_fifo.sv - self-checking bench for dumbserial_frame_rx_fifo
module tb_dumbserial_frame_rx_fifo;

    localparam int WIDTH   = 16;
    localparam int LOGSIZE = 1;
    localparam int DEPTH   = 4;
    localparam int NPKT    = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              serialClock;
    logic              serialData;
    logic [WIDTH-1:0]  out_data;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              packet_dropped;
    logic [2:0]        level;

    dumbserial_frame_rx_fifo #(
        .WIDTH(WIDTH), .LOGSIZE(LOGSIZE), .DEPTH(DEPTH), .TIMEOUT_CYCLES(255)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .serialClock    (serialClock),
        .serialData     (serialData),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .packet_dropped (packet_dropped),
        .level          (level)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int drops = 0;
    int exp_drops = 0;
    int ready_mode = 0;      // 0 stall, 1 always ready, 2 toggle, 3 random
    int cyc = 0;
    int first_valid = -1;
    logic [WIDTH:0] exp_q[$];  // {last, data} in delivery order
    logic prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic prev_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        logic [WIDTH:0] e;
        @(posedge clock);
        #1;
        cyc++;
        if (packet_dropped === 1'b1) drops++;
        if (prev_stall) begin
            chk("stall_data", 32'(out_data), 32'(prev_data));
            chk("stall_last", 32'(out_last), 32'(prev_last));
        end
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        chk("level_vs_valid", 32'(level != 3'd0), 32'(out_valid));
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && out_ready) begin
            chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pop_data", 32'(out_data), 32'(e[WIDTH-1:0]));
                chk("pop_last", 32'(out_last), 32'(e[WIDTH]));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
    endtask

    task automatic send_bit(input logic b);
        serialData  = b;
        serialClock = 1'b1;
        repeat (8) tick();
        serialClock = 1'b0;
        repeat (8) tick();
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    // Packet is accepted only if the whole packet fits beside what is
    // already committed and unread when the frame starts.
    task automatic send_frame(input logic [15:0] s0, input logic [15:0] s1);
        if (exp_q.size() + NPKT <= DEPTH) begin
            exp_q.push_back({1'b0, s0});
            exp_q.push_back({1'b1, s1});
        end else begin
            exp_drops++;
        end
        send_bits(32'hAB, 8);
        send_bits(32'(s0), 16);
        send_bits(32'(s1), 16);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 400;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        repeat (4) tick();
        chk({tag, "_level0"}, 32'(level), 32'd0);
        chk({tag, "_valid0"}, 32'(out_valid), 32'd0);
        chk({tag, "_drops"}, 32'(drops), 32'(exp_drops));
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        serialClock = 1'b0;
        serialData  = 1'b0;
        prev_stall  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        chk("rst_valid",   32'(out_valid), 32'd0);
        chk("rst_level",   32'(level), 32'd0);
        chk("rst_data",    32'(out_data), 32'd0);
        chk("rst_last",    32'(out_last), 32'd0);
        chk("rst_dropped", 32'(packet_dropped), 32'd0);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic [44:0] stream;
        int c0;
        int d0;

        out_ready = 1'b0;
        do_reset();

        // 1: basic frame, commit latency
        ready_mode  = 1;
        first_valid = -1;
        exp_q.push_back({1'b0, 16'h1234});
        exp_q.push_back({1'b1, 16'hABCD});
        send_bits(32'hAB, 8);
        send_bits(32'h1234, 16);
        send_bits(32'hABCD >> 1, 15);
        c0 = cyc;
        send_bit(1'b1);
        chk("commit_latency", 32'(first_valid - c0), 32'd7);
        drain("t1");

        // 2: noise before delimiter
        send_bits(32'b10101, 5);
        send_frame(16'h00FF, 16'hFF00);
        drain("t2");

        // 3: overflow drops the third packet whole
        ready_mode = 0;
        d0 = drops;
        send_frame(16'h0001, 16'h0002);
        send_frame(16'h0003, 16'h0004);
        send_frame(16'h0005, 16'h0006);
        chk("t3_level_full", 32'(level), 32'd4);
        chk("t3_one_drop", 32'(drops - d0), 32'd1);
        ready_mode = 1;
        drain("t3");
        send_frame(16'(($urandom)), 16'(($urandom)));
        drain("t3b");

        // 4: toggling ready during commit
        ready_mode = 2;
        send_frame(16'(($urandom)), 16'(($urandom)));
        drain("t4");

        // random frames with random backpressure
        ready_mode = 3;
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            send_frame(a, b);
        end
        drain("rnd");

        // 5: reset mid-frame discards committed and partial data
        ready_mode = 0;
        send_frame(16'(($urandom)), 16'(($urandom)));
        chk("t5_level2", 32'(level), 32'd2);
        send_bits(32'hAB, 8);
        send_bits($urandom, 10);
        do_reset();
        ready_mode = 1;
        send_frame(16'hBEEF, 16'hCAFE);
        drain("t5");

        // 6: idle gap mid-packet
        d0 = drops;
        send_bits(32'hAB, 8);
        send_bits(32'b10110, 5);
        repeat (300) tick();
`ifdef RX_TIMEOUT_EN
        chk("t6_timeout_drop", 32'(drops - d0), 32'd1);
        exp_drops++;
        send_frame(16'hBEEF, 16'hCAFE);
        drain("t6");
`else
        chk("t6_no_drop", 32'(drops - d0), 32'd0);
        stream = {5'b10110, 8'hAB, 16'hBEEF, 16'hCAFE};
        exp_q.push_back({1'b0, stream[44:29]});
        exp_q.push_back({1'b1, stream[28:13]});
        send_bits(32'hAB, 8);
        send_bits(32'hBEEF, 16);
        send_bits(32'hCAFE, 16);
        drain("t6");
        send_frame(16'h1357, 16'h2468);
        drain("t6b");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
